// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: assembles one 40-bit big-endian instruction from a
// byte-wide program ROM, one outstanding read at a time.
//
// state | meaning
// IDLE  | waiting for fetch_start; range check and request latch
// REQ   | one-cycle ROM read strobe for byte base+index
// WAIT  | waiting (unbounded) for rom_rd_valid of the outstanding read
// DONE  | instruction/pc updated atomically, instr_valid pulse
module instr_fetch_unit #(
    parameter int PROG_MEM_SIZE = 1024,
    parameter int INSTR_BYTES   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic [15:0] pc_in,
    output logic [15:0] rom_addr,
    output logic        rom_rd_en,
    input  logic [7:0]  rom_rd_data,
    input  logic        rom_rd_valid,
    output logic [39:0] instruction,
    output logic [15:0] pc,
    output logic        instr_valid,
    output logic        busy,
    output logic        fetch_fault
);

    localparam logic [18:0] MEM_LIMIT    = 19'(PROG_MEM_SIZE);
    localparam logic [18:0] INSTR_STRIDE = 19'(INSTR_BYTES);
    localparam logic [2:0]  LAST_IDX     = 3'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  byte_idx;
    logic [31:0] byte_buf;
    logic [15:0] base_q;
    logic [15:0] pc_q;
    logic [18:0] base_calc;
    logic        range_fault;

    // Full 19-bit product and compare so large pc_in values cannot wrap into range.
    assign base_calc   = {3'b000, pc_in} * INSTR_STRIDE;
    assign range_fault = (base_calc + {16'd0, LAST_IDX}) >= MEM_LIMIT;
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (fetch_start && !range_fault) state_d = REQ;
            REQ:  state_d = WAIT;
            WAIT: if (rom_rd_valid) state_d = (byte_idx == LAST_IDX) ? DONE : REQ;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            byte_idx    <= 3'd0;
            byte_buf    <= 32'd0;
            base_q      <= 16'd0;
            pc_q        <= 16'd0;
            rom_addr    <= 16'd0;
            rom_rd_en   <= 1'b0;
            instruction <= 40'd0;
            pc          <= 16'd0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_rd_en   <= (state_d == REQ);
            instr_valid <= (state_d == DONE);
            case (state_q)
                IDLE: begin
                    if (fetch_start) begin
                        if (range_fault) begin
                            fetch_fault <= 1'b1;
                        end else begin
                            fetch_fault <= 1'b0;
                            pc_q        <= pc_in;
                            base_q      <= base_calc[15:0];
                            rom_addr    <= base_calc[15:0];
                            byte_idx    <= 3'd0;
                        end
                    end
                end
                WAIT: begin
                    if (rom_rd_valid) begin
                        if (byte_idx == LAST_IDX) begin
                            // Last byte lands directly so instruction and pc change together.
                            instruction <= {byte_buf, rom_rd_data};
                            pc          <= pc_q;
                        end else begin
                            byte_buf <= {byte_buf[23:0], rom_rd_data};
                            byte_idx <= byte_idx + 3'd1;
                            rom_addr <= base_q + {13'd0, byte_idx} + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a variable-latency ROM responder.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic [15:0] pc_in;
    logic [15:0] rom_addr;
    logic        rom_rd_en;
    logic [7:0]  rom_rd_data;
    logic        rom_rd_valid;
    logic [39:0] instruction;
    logic [15:0] pc;
    logic        instr_valid;
    logic        busy;
    logic        fetch_fault;

    instr_fetch_unit #(.PROG_MEM_SIZE(1024), .INSTR_BYTES(5)) dut (
        .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_in(pc_in),
        .rom_addr(rom_addr), .rom_rd_en(rom_rd_en), .rom_rd_data(rom_rd_data),
        .rom_rd_valid(rom_rd_valid), .instruction(instruction), .pc(pc),
        .instr_valid(instr_valid), .busy(busy), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    logic [7:0]  rom [0:1023];
    int          lat_cnt = 0;
    int          slow_addr = -1;
    int          slow_lat = 3;
    int          rd_count = 0;
    int          overlap_err = 0;
    logic [15:0] addr_q[$];
    logic [15:0] cur_addr = 16'd0;
    logic        model_valid = 1'b0;
    logic        stray_valid = 1'b0;
    logic [7:0]  model_data = 8'd0;

    assign rom_rd_valid = model_valid | stray_valid;
    assign rom_rd_data  = model_data;

    // ROM responder: valid appears lat cycles after the strobe cycle.
    always @(negedge clk) begin
        model_valid = 1'b0;
        if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                model_valid = 1'b1;
                model_data  = rom[cur_addr];
            end
        end
        if (rom_rd_en === 1'b1) begin
            if (lat_cnt > 0) overlap_err++;
            rd_count++;
            addr_q.push_back(rom_addr);
            cur_addr = rom_addr;
            lat_cnt  = (int'(rom_addr) == slow_addr) ? slow_lat : 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int gcyc     = 0;
    int stable_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        gcyc++;
    endtask

    // Starts a fetch in the current cycle (cycle 0); returns at the cycle after instr_valid.
    task automatic run_fetch(input logic [15:0] p, input int ign_a, input int ign_b,
                             output int vcyc, output int vgcyc);
        int busy_bad;
        logic [39:0] prev;
        busy_bad = 0;
        vcyc = -1;
        vgcyc = 0;
        prev = instruction;
        pc_in = p;
        fetch_start = 1'b1;
        cyc = 0;
        while (cyc < 60 && vcyc < 0) begin
            tick();
            fetch_start = (cyc == ign_a || cyc == ign_b);
            if (busy !== 1'b1) busy_bad++;
            if (instr_valid === 1'b1) begin
                vcyc = cyc;
                vgcyc = gcyc;
            end else if (instruction !== prev) begin
                stable_err++;
            end
        end
        tick();
        fetch_start = 1'b0;
        check("busy_during_fetch", busy_bad, 0);
        check("idle_after_done", busy, 0);
    endtask

    int v1, g1, v2, g2, rd_base, vcount;

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
        rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44; rom[4] = 8'h55;
        rom[5] = 8'h05; rom[6] = 8'h00; rom[7] = 8'h02; rom[8] = 8'h00; rom[9] = 8'h07;
        rom[10] = 8'hAA; rom[11] = 8'hBB; rom[12] = 8'hCC; rom[13] = 8'hDD; rom[14] = 8'hEE;
        rom[1015] = 8'h01; rom[1016] = 8'h02; rom[1017] = 8'h03; rom[1018] = 8'h04; rom[1019] = 8'h05;

        reset = 1'b1;
        fetch_start = 1'b1;   // dropped: reset wins
        pc_in = 16'd1;
        repeat (3) tick();
        check("rst_instruction", instruction, 40'd0);
        check("rst_pc", pc, 16'd0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_fault", fetch_fault, 1'b0);
        check("rst_rd_en", rom_rd_en, 1'b0);
        check("rst_rom_addr", rom_addr, 16'd0);
        fetch_start = 1'b0;
        reset = 1'b0;
        tick();
        check("no_fetch_after_rst", busy, 1'b0);

        // Nominal fetch, 1-cycle ROM latency
        addr_q.delete();
        run_fetch(16'd1, -1, -1, v1, g1);
        check("nom_valid_cycle", v1, 11);
        check("nom_instruction", instruction, 40'h05_00_02_00_07);
        check("nom_pc", pc, 16'd1);
        check("nom_rd_count", addr_q.size(), 5);
        for (int i = 0; i < 5 && i < addr_q.size(); i++)
            check("nom_rom_addr", addr_q[i], 16'(5 + i));

        // Byte 2 (addr 7) with 3-cycle latency
        slow_addr = 7;
        run_fetch(16'd1, -1, -1, v1, g1);
        slow_addr = -1;
        check("varlat_valid_cycle", v1, 13);
        check("varlat_instruction", instruction, 40'h05_00_02_00_07);
        check("varlat_overlap", overlap_err, 0);

        // Out of range: base 1020, last byte 1024
        rd_base = rd_count;
        vcount = 0;
        pc_in = 16'd204;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("oor_fault", fetch_fault, 1'b1);
        check("oor_busy", busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (instr_valid === 1'b1) vcount++;
        end
        check("oor_no_reads", rd_count - rd_base, 0);
        check("oor_no_valid", vcount, 0);
        check("oor_instr_hold", instruction, 40'h05_00_02_00_07);
        check("oor_pc_hold", pc, 16'd1);
        run_fetch(16'd203, -1, -1, v1, g1);
        check("edge_instruction", instruction, 40'h01_02_03_04_05);
        check("edge_pc", pc, 16'd203);
        check("edge_fault_clear", fetch_fault, 1'b0);

        // Ignored fetch_start during fetch, stray valid in IDLE
        rd_base = rd_count;
        run_fetch(16'd2, 3, 11, v1, g1);
        check("ign_valid_cycle", v1, 11);
        stray_valid = 1'b1;
        tick();
        stray_valid = 1'b0;
        vcount = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (instr_valid === 1'b1 || busy === 1'b1) vcount++;
        end
        check("ign_no_activity", vcount, 0);
        check("ign_rd_count", rd_count - rd_base, 5);
        check("ign_instruction", instruction, 40'hAA_BB_CC_DD_EE);
        check("ign_pc", pc, 16'd2);

        // Reset in cycle 6 of a fetch
        vcount = 0;
        pc_in = 16'd1;
        fetch_start = 1'b1;
        cyc = 0;
        while (cyc < 6) begin
            tick();
            fetch_start = 1'b0;
            if (instr_valid === 1'b1) vcount++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_instruction", instruction, 40'd0);
        check("mid_rst_pc", pc, 16'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rd_en", rom_rd_en, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (instr_valid === 1'b1 || busy === 1'b1) vcount++;
        end
        check("mid_rst_no_valid", vcount, 0);
        run_fetch(16'd0, -1, -1, v1, g1);
        check("post_rst_valid_cycle", v1, 11);
        check("post_rst_instruction", instruction, 40'h11_22_33_44_55);
        check("post_rst_pc", pc, 16'd0);

        // Back-to-back
        run_fetch(16'd1, -1, -1, v1, g1);
        check("b2b_first_instr", instruction, 40'h05_00_02_00_07);
        run_fetch(16'd2, -1, -1, v2, g2);
        check("b2b_spacing", g2 - g1, 12);
        check("b2b_second_instr", instruction, 40'hAA_BB_CC_DD_EE);
        check("b2b_second_pc", pc, 16'd2);
        check("instr_stable_between", stable_err, 0);
        check("no_overlapped_reads", overlap_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sits directly upstream of the control unit.
- On request, fetches one 40-bit instruction at instruction index pc from a byte-wide program ROM, one byte per read.
- Assembles the five bytes into a stable instruction register that drives the control unit's instruction input.
- The ROM read handshake has variable latency; the block allows one outstanding read at a time.

Parameters:
- PROG_MEM_SIZE, 1024, program ROM size in bytes; valid byte addresses are 0..PROG_MEM_SIZE-1.
- INSTR_BYTES, 5, bytes per instruction; fixed at 5 because the instruction is 40 bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_start  in  1  request pulse; sampled only in IDLE.
- pc_in  in  16  instruction index to fetch (next_pc from the control unit).
- rom_addr  out  16  ROM byte address; meaningful while rom_rd_en=1.
- rom_rd_en  out  1  one-cycle ROM read strobe.
- rom_rd_data  in  8  ROM read byte; qualified by rom_rd_valid.
- rom_rd_valid  in  1  ROM data valid; arrives 1 or more cycles after rom_rd_en.
- instruction  out  40  last completely fetched instruction.
- pc  out  16  index of the instruction currently held on the instruction output.
- instr_valid  out  1  one-cycle pulse when the instruction output updates.
- busy  out  1  high in every state except IDLE.
- fetch_fault  out  1  sticky out-of-range flag.

Behaviour:
- Reset values: instruction=0, pc=0, instr_valid=0, busy=0, fetch_fault=0, rom_rd_en=0, rom_addr=0, byte index=0, state=IDLE.
- Reset mid-fetch aborts the fetch. The partial byte buffer is discarded and not copied to the outputs.
- Address computation: base = pc_in*5, computed in 19 bits. Fault if base+4 >= PROG_MEM_SIZE (19-bit compare, no truncation).
- Byte order is big-endian. Byte at base+0 goes to instruction[39:32] (opcode), base+1 to [31:24], and so on; base+4 goes to [7:0].
- State IDLE:
  - fetch_start=1 and fault: fetch_fault<=1, stay IDLE, no ROM access. instruction and pc are unchanged and no instr_valid pulse occurs.
  - fetch_start=1 and in range: latch pc_in and base, fetch_fault<=0, byte index<=0, go to REQ.
- State REQ: rom_rd_en=1, rom_addr=base+index (low 16 bits) for exactly one cycle, then go to WAIT.
- State WAIT:
  - rom_rd_en=0.
  - On rom_rd_valid=1: write rom_rd_data into buffer slot index.
  - If index==4, go to DONE; otherwise index++ and go to REQ.
  - Without rom_rd_valid, stay in WAIT indefinitely. There is no timeout.
- State DONE:
  - Copy the full buffer to instruction and the latched pc to pc in a single cycle (atomic update).
  - instr_valid=1 for this one cycle, then go to IDLE.
- instr_valid and rom_rd_en are registered outputs.
- rom_rd_valid outside WAIT is ignored. This includes a valid arriving in the same cycle as rom_rd_en.
- fetch_start outside IDLE is ignored; it is neither queued nor counted.
- fetch_start in the same cycle as reset: reset wins and the request is dropped.
- instruction and pc hold their values between fetches, so the control unit always sees a stable word.
- Latency with rom_rd_valid exactly 1 cycle after rom_rd_en:
  - fetch_start sampled at cycle 0; REQ at cycles 1, 3, 5, 7, 9; valids at cycles 2, 4, 6, 8, 10.
  - DONE (instr_valid=1) at cycle 11. Back-to-back throughput is 1 instruction per 12 cycles.
- Each additional cycle of ROM latency adds 1 cycle per byte.

Test Plan:
- Nominal fetch: ROM bytes 0x05..0x09 = 05 00 02 00 07, fetch_start with pc_in=1 at 1-cycle ROM latency -> rom_addr sequence 5, 6, 7, 8, 9; instr_valid at cycle 11; instruction=0x0500020007; pc=1; busy high for cycles 1-11 (REQ/WAIT/DONE), IDLE again at cycle 12.
- Variable latency: same fetch with ROM latency 3 cycles for byte 2 only -> identical instruction; instr_valid at cycle 13; rom_rd_en never asserted while a read is outstanding.
- Out of range, PROG_MEM_SIZE=1024: pc_in=204 (base 1020, 1024 >= 1024) -> fetch_fault=1, no rom_rd_en, instruction and pc unchanged. Next fetch with pc_in=203 (bytes 1015..1019) succeeds and fetch_fault=0.
- Ignored requests: fetch_start pulsed at cycles 3 and 11 during a fetch, plus a stray rom_rd_valid while in IDLE -> only one fetch occurs, no extra ROM reads, outputs unaffected.
- Reset mid-fetch: after a successful fetch of 0xAABBCCDDEE, start a new fetch and assert reset at cycle 6 -> next cycle instruction=0, pc=0, busy=0, rom_rd_en=0, no instr_valid. A subsequent fetch of pc_in=0 returns ROM bytes 0..4 correctly.
- Back-to-back: fetch_start pulsed in the IDLE cycle right after instr_valid -> second fetch begins immediately; instr_valid pulses are 12 cycles apart; the instruction output updates only at each DONE cycle.
